pcm_mem_rr_arbiter: RTL

Round-robin arbiter sharing the single PCM on-chip memory port between four CPU requesters. Each CPU issues a level-held request with a one-cycle ready completion pulse. The arbiter serialises the requests into single-beat memory-mapped accesses and returns read data per requester. It sits between the four CPU request buses and the pcm_mem_mm memory slave, in place of ad-hoc position-counting schedulers.

---
 rtl/pcm_arb_pkg.sv | 29 ++
 rtl/pcm_rr_pick.sv | 37 +++
 rtl/pcm_mem_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_arb_pkg.sv
// -----------------------------------------------------------------------------
// pcm_arb_pkg
// Shared types and constants for the PCM memory round-robin arbiter.
//   state_t     : arbiter FSM states
//   NUM_REQ     : number of CPU requesters sharing the memory port
//   RD_LAT_MAX  : largest supported memory read latency (cycles)
//   req_rec_t   : one requester's access record {write, addr, wdata}
// -----------------------------------------------------------------------------
package pcm_arb_pkg;

    localparam int NUM_REQ    = 4;
    localparam int RD_LAT_MAX = 4;
    localparam int CPU_AW     = 20;
    localparam int DATA_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic              write;
        logic [CPU_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_rec_t;

endpackage : pcm_arb_pkg

// File: rtl/pcm_rr_pick.sv
// -----------------------------------------------------------------------------
// pcm_rr_pick
// Combinational rotating-priority picker. The requester just after
// i_last_grant has the highest priority; i_last_grant itself has the lowest.
// Ports:
//   i_req        in  NUM_REQ  request vector
//   i_last_grant in  2        id granted most recently
//   o_winner     out 2        selected requester (meaningful when o_valid)
//   o_valid      out 1        at least one request present
// -----------------------------------------------------------------------------
module pcm_rr_pick
    import pcm_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_last_grant,
    output logic [1:0]         o_winner,
    output logic               o_valid
);

    logic [1:0] w_idx;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        o_winner = i_last_grant;
        o_valid  = |i_req;
        w_idx    = '0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = i_last_grant + 2'(i + 1);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
            end
        end
    end

endmodule : pcm_rr_pick

// File: rtl/pcm_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pcm_mem_rr_arbiter
// Shares the single-port PCM on-chip memory between four CPU requesters.
// Requests are level-held until a one-cycle ready pulse; accesses are
// serialised one at a time with round-robin fairness.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   cpuN_req/write/addr/data_in  request bus from CPU N (N = 0..3)
//   cpuN_ready                 one-cycle completion pulse
//   cpuN_data_out              last read data for CPU N (held between reads)
//   cpuN_err                   out-of-range flag, coincident with ready
//   pcm_mem_mm_*               memory-mapped slave port
//
// Build option:
//   PCM_ARB_RANGE_CHECK_EN  when defined, a winner whose address has any bit
//                           set above MEM_AW completes at once with err=1 and
//                           no memory access. When undefined, upper address
//                           bits are ignored and err stays 0.
// -----------------------------------------------------------------------------
module pcm_mem_rr_arbiter
    import pcm_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MEM_AW       = 11
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu0_req,
    input  logic              cpu0_write,
    input  logic [19:0]       cpu0_addr,
    input  logic [15:0]       cpu0_data_in,
    output logic              cpu0_ready,
    output logic [15:0]       cpu0_data_out,
    output logic              cpu0_err,

    input  logic              cpu1_req,
    input  logic              cpu1_write,
    input  logic [19:0]       cpu1_addr,
    input  logic [15:0]       cpu1_data_in,
    output logic              cpu1_ready,
    output logic [15:0]       cpu1_data_out,
    output logic              cpu1_err,

    input  logic              cpu2_req,
    input  logic              cpu2_write,
    input  logic [19:0]       cpu2_addr,
    input  logic [15:0]       cpu2_data_in,
    output logic              cpu2_ready,
    output logic [15:0]       cpu2_data_out,
    output logic              cpu2_err,

    input  logic              cpu3_req,
    input  logic              cpu3_write,
    input  logic [19:0]       cpu3_addr,
    input  logic [15:0]       cpu3_data_in,
    output logic              cpu3_ready,
    output logic [15:0]       cpu3_data_out,
    output logic              cpu3_err,

    output logic [MEM_AW-1:0] pcm_mem_mm_address,
    output logic              pcm_mem_mm_chipselect,
    output logic              pcm_mem_mm_clken,
    output logic              pcm_mem_mm_write,
    input  logic [15:0]       pcm_mem_mm_readdata,
    output logic [15:0]       pcm_mem_mm_writedata,
    output logic [1:0]        pcm_mem_mm_byteenable
);

    localparam int LAT_W = $clog2(RD_LAT_MAX);

    // ---------------------------------------------------------------- inputs
    logic [NUM_REQ-1:0] w_req;
    req_rec_t           w_rec [NUM_REQ];
    req_rec_t           w_win_rec;
    logic [1:0]         w_win;
    logic               w_win_vld;
    logic               w_oor;
    logic               w_unused;

    assign w_req    = {cpu3_req, cpu2_req, cpu1_req, cpu0_req};
    assign w_rec[0] = '{write: cpu0_write, addr: cpu0_addr, wdata: cpu0_data_in};
    assign w_rec[1] = '{write: cpu1_write, addr: cpu1_addr, wdata: cpu1_data_in};
    assign w_rec[2] = '{write: cpu2_write, addr: cpu2_addr, wdata: cpu2_data_in};
    assign w_rec[3] = '{write: cpu3_write, addr: cpu3_addr, wdata: cpu3_data_in};

    // --------------------------------------------------------------- state
    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_id;
    logic [1:0]          r_last_grant;
    logic [MEM_AW-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic                r_write;
    logic                r_err;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [15:0]         r_dout [NUM_REQ];

    pcm_rr_pick u_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_win),
        .o_valid      (w_win_vld)
    );

    assign w_win_rec = w_rec[w_win];

`ifdef PCM_ARB_RANGE_CHECK_EN
    assign w_oor = (w_win_rec.addr >> MEM_AW) != '0;
`else
    assign w_oor = 1'b0;
`endif

    // Upper address bits are only inspected by the range check.
    assign w_unused = ^w_win_rec.addr;

    // ------------------------------------------------------ state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------- next state and outputs
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_err;
    logic               w_cs;
    logic               w_we;
    logic [MEM_AW-1:0]  w_mem_addr;
    logic [15:0]        w_mem_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_err       = '0;
        w_cs        = 1'b0;
        w_we        = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                // Out-of-range winners complete without touching memory.
                if (w_win_vld) begin
                    w_state_nxt = w_oor ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cs        = 1'b1;
                w_we        = r_write;
                w_mem_addr  = r_addr;
                w_mem_wdata = r_wdata;
                w_state_nxt = r_write ? ST_DONE : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ready[r_id] = 1'b1;
                w_err[r_id]   = r_err;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // NOTE: the per-requester data_out registers are reset explicitly because
    // their value is architecturally visible right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id         <= '0;
            r_last_grant <= 2'd3;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_lat_cnt    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_dout[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_id    <= w_win;
                        r_addr  <= w_win_rec.addr[MEM_AW-1:0];
                        r_wdata <= w_win_rec.wdata;
                        r_write <= w_win_rec.write;
                        r_err   <= w_oor;
                    end
                end
                ST_ISSUE: begin
                    if (!r_write) begin
                        r_lat_cnt <= LAT_W'(READ_LATENCY - 1);
                    end
                end
                ST_RD_WAIT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end else begin
                        r_dout[r_id] <= pcm_mem_mm_readdata;
                    end
                end
                ST_DONE: begin
                    r_last_grant <= r_id;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    assign cpu0_ready    = w_ready[0];
    assign cpu1_ready    = w_ready[1];
    assign cpu2_ready    = w_ready[2];
    assign cpu3_ready    = w_ready[3];
    assign cpu0_err      = w_err[0];
    assign cpu1_err      = w_err[1];
    assign cpu2_err      = w_err[2];
    assign cpu3_err      = w_err[3];
    assign cpu0_data_out = r_dout[0];
    assign cpu1_data_out = r_dout[1];
    assign cpu2_data_out = r_dout[2];
    assign cpu3_data_out = r_dout[3];

    assign pcm_mem_mm_address    = w_mem_addr;
    assign pcm_mem_mm_chipselect = w_cs;
    assign pcm_mem_mm_write      = w_we;
    assign pcm_mem_mm_writedata  = w_mem_wdata;
    assign pcm_mem_mm_clken      = 1'b1;
    assign pcm_mem_mm_byteenable = 2'b11;

endmodule : pcm_mem_rr_arbiter
